reg_file_vliw_sb: RTL

REG_FILE_VLIW_SB -- requirements
Module: reg_file_vliw_sb

---
 rtl/vliw_pkg.sv | 11 +
 rtl/reg_file_wsel.sv | 29 ++
 rtl/reg_file_vliw_sb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared sizing constants for the VLIW register file.
//   NLANE_D : default number of issue lanes
//   XLEN_D  : default data width
//   NREG_D  : default architectural register count
//   CNT_W   : width of the write-conflict cycle counter
package vliw_pkg;
    localparam int NLANE_D = 4;
    localparam int XLEN_D  = 32;
    localparam int NREG_D  = 64;
    localparam int CNT_W   = 16;
endpackage

// File: rtl/reg_file_wsel.sv
// Write-select: finds which lane (if any) is writing a query address.
//   we_i  : per-lane write enables (already qualified by the caller)
//   wa_i  : per-lane write addresses, lane l at [l*AW +: AW]
//   qa_i  : query address
//   hit_o : some enabled lane writes qa_i
//   idx_o : winning lane, highest index wins
module reg_file_wsel #(
    parameter int NLANE = 4,
    parameter int AW    = 6,
    parameter int LW    = 2
) (
    input  logic [NLANE-1:0]    we_i,
    input  logic [NLANE*AW-1:0] wa_i,
    input  logic [AW-1:0]       qa_i,
    output logic                hit_o,
    output logic [LW-1:0]       idx_o
);
    // Ascending scan: a later (higher) lane overrides an earlier match.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int l = 0; l < NLANE; l++) begin
            if (we_i[l] && (wa_i[l*AW +: AW] == qa_i)) begin
                hit_o = 1'b1;
                idx_o = LW'(l);
            end
        end
    end
endmodule

// File: rtl/reg_file_vliw_sb.sv
// Multi-lane register file with same-cycle bypass, a per-register pending
// scoreboard and same-cycle write-conflict monitoring.
//   clk, rstn        : clock, async active-low reset
//   we/wa/wd         : per-lane write port
//   ra1/ra2, rd1/rd2 : per-lane combinational read ports (with bypass)
//   pset/pa          : per-lane "mark destination pending" strobe and address
//   busy1/busy2      : per-lane source-pending flags
//   wconf, conf_cnt  : sticky conflict flag and saturating conflict-cycle count
//   wconf_clr        : synchronous clear of wconf and conf_cnt
module reg_file_vliw_sb import vliw_pkg::*; #(
    parameter int NLANE    = NLANE_D,
    parameter int XLEN     = XLEN_D,
    parameter int NREG     = NREG_D,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG),
    localparam int LW      = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NLANE-1:0]      we,
    input  logic [NLANE*AW-1:0]   wa,
    input  logic [NLANE*XLEN-1:0] wd,
    input  logic [NLANE*AW-1:0]   ra1,
    input  logic [NLANE*AW-1:0]   ra2,
    output logic [NLANE*XLEN-1:0] rd1,
    output logic [NLANE*XLEN-1:0] rd2,
    input  logic [NLANE-1:0]      pset,
    input  logic [NLANE*AW-1:0]   pa,
    output logic [NLANE-1:0]      busy1,
    output logic [NLANE-1:0]      busy2,
    output logic                  wconf,
    input  logic                  wconf_clr,
    output logic [CNT_W-1:0]      conf_cnt
);
    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

    // Address names a real, writable register (not out of range, not hardwired r0).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [NREG-1:0][XLEN-1:0] regs_q;
    logic [NREG-1:0]           pend_q;
    logic                      wconf_q, wconf_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    // Writes to r0 / out-of-range addresses are dropped before they reach
    // storage, bypass or conflict detection.
    logic [NLANE-1:0] we_eff;
    logic [NLANE-1:0] cf_lane;

    logic [1:0][NLANE*AW-1:0]   ra_p;
    logic [1:0][NLANE*XLEN-1:0] rd_p;
    logic [1:0][NLANE-1:0]      busy_p;

    assign ra_p[0] = ra1;
    assign ra_p[1] = ra2;
    assign rd1     = rd_p[0];
    assign rd2     = rd_p[1];
    assign busy1   = busy_p[0];
    assign busy2   = busy_p[1];

    for (genvar i = 0; i < NLANE; i++) begin : g_wlane
        logic          cf_hit;
        logic [LW-1:0] cf_idx;

        assign we_eff[i] = we[i] & addr_ok(wa[i*AW +: AW]);

        // Any other lane winning this lane's own address means a duplicate.
        reg_file_wsel #(.NLANE(NLANE), .AW(AW), .LW(LW)) u_cf (
            .we_i (we_eff),
            .wa_i (wa),
            .qa_i (wa[i*AW +: AW]),
            .hit_o(cf_hit),
            .idx_o(cf_idx)
        );
        assign cf_lane[i] = we_eff[i] & cf_hit & (cf_idx != LW'(i));
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        for (genvar i = 0; i < NLANE; i++) begin : g_lane
            logic [AW-1:0] qa;
            logic          hit;
            logic [LW-1:0] idx;

            assign qa = ra_p[p][i*AW +: AW];

            reg_file_wsel #(.NLANE(NLANE), .AW(AW), .LW(LW)) u_wsel (
                .we_i (we_eff),
                .wa_i (wa),
                .qa_i (qa),
                .hit_o(hit),
                .idx_o(idx)
            );

            assign rd_p[p][i*XLEN +: XLEN] = !addr_ok(qa) ? '0 :
                                             hit ? wd[idx*XLEN +: XLEN] : regs_q[qa];
            // A same-cycle write retires the pending op, so it is not busy.
            assign busy_p[p][i] = addr_ok(qa) & pend_q[qa] & ~hit;
        end
    end

    always_comb begin
        wconf_d = wconf_q;
        cnt_d   = cnt_q;
        if (wconf_clr) begin
            wconf_d = 1'b0;
            cnt_d   = '0;
        end else if (|cf_lane) begin
            wconf_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs_q  <= '0;
            pend_q  <= '0;
            wconf_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // Later lanes' assignments override earlier ones: highest lane wins.
            for (int l = 0; l < NLANE; l++) begin
                if (we_eff[l]) begin
                    regs_q[wa[l*AW +: AW]] <= wd[l*XLEN +: XLEN];
                    pend_q[wa[l*AW +: AW]] <= 1'b0;
                end
            end
            // Sets come after clears so a same-cycle set keeps the bit.
            for (int l = 0; l < NLANE; l++) begin
                if (pset[l] && addr_ok(pa[l*AW +: AW])) pend_q[pa[l*AW +: AW]] <= 1'b1;
            end
            wconf_q <= wconf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wconf    = wconf_q;
    assign conf_cnt = cnt_q;
endmodule
